// File: rtl/piso_stream.sv
// ---------------------------------------------------------------------------
// piso_stream
//   Parallel-in / serial-out shifter with a valid/ready load handshake.
//   A word is accepted on i_load_valid && o_load_ready. Its bits then appear
//   one at a time on o_so. Each i_shift_en pulse (a baud tick) consumes the
//   current bit. A new word may be accepted on the same edge that consumes the
//   final bit of the current word, so words can stream with no idle gap.
//
//   Optional feature macro: PISO_PARITY_EN
//     When defined, the even parity (^pi) is captured at load. It is sent as
//     one extra bit after the data bits, and o_last marks that parity bit.
//
// Parameters
//   WIDTH       data word width (>= 2)
//   LSB_FIRST   1: pi[0] goes out first, 0: pi[WIDTH-1] goes out first
//   IDLE_LEVEL  level on o_so while no word is active
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_load_valid   source presents a word on i_pi
//   o_load_ready   block accepts a word this cycle
//   i_pi           parallel word, sampled on the handshake
//   i_shift_en     consume the current serial bit at this edge
//   o_so           current serial bit
//   o_so_valid     o_so carries a word (or parity) bit
//   o_last         o_so carries the final bit of the current word
//   o_busy         word in flight
// ---------------------------------------------------------------------------
module piso_stream #(
   parameter int   WIDTH      = 8,
   parameter int   LSB_FIRST  = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   input  logic [WIDTH-1:0] i_pi,
   input  logic             i_shift_en,
   output logic             o_so,
   output logic             o_so_valid,
   output logic             o_last,
   output logic             o_busy
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_shreg;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   w_shreg_shifted;
   logic               w_out_bit;
   logic               w_cnt_last;
   logic               w_word_end;
   logic               w_load;
`ifdef PISO_PARITY_EN
   logic               r_par;
`endif

   // Bit-order selection: the output end of the shift register and the
   // direction of the shift both follow LSB_FIRST.
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign w_out_bit       = r_shreg[0];
         assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      end else begin : g_msb_first
         assign w_out_bit       = r_shreg[WIDTH-1];
         assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      end
   endgenerate

   assign w_cnt_last = (r_cnt == CNT_LAST);

   // The word ends when its final bit (data bit WIDTH-1, or the parity bit)
   // is consumed. That edge is the only one in a word where a new load can
   // be accepted.
`ifdef PISO_PARITY_EN
   assign w_word_end = i_shift_en && (r_state == S_PAR);
`else
   assign w_word_end = i_shift_en && (r_state == S_SHIFT) && w_cnt_last;
`endif

   assign w_load = i_load_valid && o_load_ready;

   // ---------------- state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_load_valid) begin
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (i_shift_en && w_cnt_last) begin
`ifdef PISO_PARITY_EN
               w_state_next = S_PAR;
`else
               w_state_next = i_load_valid ? S_SHIFT : S_IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         S_PAR: begin
            if (i_shift_en) begin
               w_state_next = i_load_valid ? S_SHIFT : S_IDLE;
            end
         end
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Outputs decode registers only, except o_load_ready, which must see the
   // word-end edge to allow gapless back-to-back loads.
   always_comb begin
      o_so         = IDLE_LEVEL;
      o_so_valid   = 1'b0;
      o_last       = 1'b0;
      o_busy       = 1'b0;
      o_load_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_load_ready = 1'b1;
         end
         S_SHIFT: begin
            o_so         = w_out_bit;
            o_so_valid   = 1'b1;
            o_busy       = 1'b1;
`ifndef PISO_PARITY_EN
            o_last       = w_cnt_last;
`endif
            o_load_ready = w_word_end;
         end
`ifdef PISO_PARITY_EN
         S_PAR: begin
            o_so         = r_par;
            o_so_valid   = 1'b1;
            o_busy       = 1'b1;
            o_last       = 1'b1;
            o_load_ready = w_word_end;
         end
`endif
         default: begin
            o_so = IDLE_LEVEL;
         end
      endcase
   end

   // ---------------- datapath ----------------
   // After the last data bit, cnt reaches WIDTH. It then holds until the
   // next load, so it never exceeds WIDTH.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shreg <= '0;
         r_cnt   <= '0;
`ifdef PISO_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_load) begin
         r_shreg <= i_pi;
         r_cnt   <= '0;
`ifdef PISO_PARITY_EN
         r_par   <= ^i_pi;
`endif
      end else if ((r_state == S_SHIFT) && i_shift_en) begin
         r_shreg <= w_shreg_shifted;
         r_cnt   <= r_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// ---------------------------------------------------------------------------
// tb_piso_stream
//   Directed bench for piso_stream. Two instances share every input:
//   u_lsb (LSB_FIRST=1, IDLE_LEVEL=0) and u_msb (LSB_FIRST=0, IDLE_LEVEL=1).
//   Build with +define+PISO_PARITY_EN to exercise the parity word format.
// ---------------------------------------------------------------------------
module tb_piso_stream;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load_valid;
   logic         shift_en;
   logic [W-1:0] pi;

   logic l_ready, l_so, l_so_valid, l_last, l_busy;
   logic m_ready, m_so, m_so_valid, m_last, m_busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   piso_stream #(.WIDTH(W), .LSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(load_valid),
      .o_load_ready(l_ready), .i_pi(pi), .i_shift_en(shift_en),
      .o_so(l_so), .o_so_valid(l_so_valid), .o_last(l_last), .o_busy(l_busy)
   );

   piso_stream #(.WIDTH(W), .LSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_msb (
      .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(load_valid),
      .o_load_ready(m_ready), .i_pi(pi), .i_shift_en(shift_en),
      .o_so(m_so), .o_so_valid(m_so_valid), .o_last(m_last), .o_busy(m_busy)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are checked
   // 4 units after the edge, well before the next one.
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #3;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_lsb_so"},       l_so,       1'b0);
      chk({tag, "_msb_so"},       m_so,       1'b1);
      chk({tag, "_lsb_so_valid"}, l_so_valid, 1'b0);
      chk({tag, "_msb_so_valid"}, m_so_valid, 1'b0);
      chk({tag, "_lsb_busy"},     l_busy,     1'b0);
      chk({tag, "_msb_busy"},     m_busy,     1'b0);
      chk({tag, "_lsb_last"},     l_last,     1'b0);
      chk({tag, "_lsb_ready"},    l_ready,    1'b1);
      chk({tag, "_msb_ready"},    m_ready,    1'b1);
   endtask

   // Loads word w from IDLE, then consumes it with one shift_en pulse every
   // 'gap' cycles. i_pi is scrambled after the handshake to show it is ignored.
   task automatic run_word(input string tag, input logic [W-1:0] w, input int gap);
      logic exp_l, exp_m;
      load_valid = 1'b1;
      pi         = w;
      shift_en   = 1'b0;
      settle;
      chk({tag, "_handshake_ready"}, l_ready, 1'b1);
      next_cycle;
      load_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         for (int h = 0; h < gap; h++) begin
            shift_en = (h == gap - 1);
            pi       = W'($urandom);
            settle;
            exp_l = (i < W) ? w[i]         : ^w;
            exp_m = (i < W) ? w[W - 1 - i] : ^w;
            chk($sformatf("%s_b%0d_lsb_so", tag, i), l_so, exp_l);
            chk($sformatf("%s_b%0d_msb_so", tag, i), m_so, exp_m);
            chk($sformatf("%s_b%0d_so_valid", tag, i), l_so_valid, 1'b1);
            chk($sformatf("%s_b%0d_busy", tag, i), m_busy, 1'b1);
            chk($sformatf("%s_b%0d_lsb_last", tag, i), l_last, i == NB - 1);
            chk($sformatf("%s_b%0d_msb_last", tag, i), m_last, i == NB - 1);
            chk($sformatf("%s_b%0d_ready", tag, i), l_ready,
                (i == NB - 1) && (h == gap - 1));
            next_cycle;
         end
      end
      shift_en = 1'b0;
      settle;
      chk_idle({tag, "_end"});
      $display("[TB] word %s pi=%h gap=%0d done, fails so far %0d", tag, w, gap, n_fail);
      next_cycle;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       exp_b;
      logic [W-1:0] wd;
      int         bi;

      // ---- reset state ----
      rst_n      = 1'b0;
      load_valid = 1'b0;
      shift_en   = 1'b0;
      pi         = '0;
      #12;
      chk_idle("reset");
      rst_n = 1'b1;
      next_cycle;
      $display("[TB] reset state checked");

      // ---- single words, shift every cycle ----
      run_word("a5", 8'hA5, 1);
      run_word("80", 8'h80, 1);

      // ---- shift_en while idle is ignored ----
      for (int k = 0; k < 3; k++) begin
         shift_en = 1'b1;
         settle;
         chk_idle($sformatf("idle_shift%0d", k));
         next_cycle;
      end
      shift_en = 1'b0;
      $display("[TB] idle shift_en ignored checked");

      // ---- shift_en every 3rd cycle ----
      run_word("3c", 8'h3C, 3);

`ifdef PISO_PARITY_EN
      // ---- parity words: 07 -> parity 1, 03 -> parity 0 ----
      run_word("par07", 8'h07, 1);
      run_word("par03", 8'h03, 1);
`endif

      // ---- back-to-back: FF then 00 with load_valid held ----
      load_valid = 1'b1;
      pi         = 8'hFF;
      shift_en   = 1'b1;
      settle;
      chk("b2b_first_ready", l_ready, 1'b1);
      next_cycle;
      for (int k = 0; k < 2 * NB; k++) begin
         bi         = k % NB;
         wd         = (k < NB) ? 8'hFF : 8'h00;
         load_valid = (k < NB);
         pi         = (k < NB) ? 8'h00 : W'($urandom);
         shift_en   = 1'b1;
         settle;
         exp_b = (bi < W) ? wd[bi] : ^wd;
         chk($sformatf("b2b_k%0d_lsb_so", k), l_so, exp_b);
         chk($sformatf("b2b_k%0d_msb_so", k), m_so, exp_b);
         chk($sformatf("b2b_k%0d_busy", k), l_busy, 1'b1);
         chk($sformatf("b2b_k%0d_so_valid", k), m_so_valid, 1'b1);
         chk($sformatf("b2b_k%0d_last", k), l_last, bi == NB - 1);
         chk($sformatf("b2b_k%0d_lsb_ready", k), l_ready, bi == NB - 1);
         chk($sformatf("b2b_k%0d_msb_ready", k), m_ready, bi == NB - 1);
         next_cycle;
      end
      load_valid = 1'b0;
      shift_en   = 1'b0;
      settle;
      chk_idle("b2b_end");
      $display("[TB] back-to-back FF/00 done, fails so far %0d", n_fail);
      next_cycle;

      // ---- asynchronous reset mid-word ----
      load_valid = 1'b1;
      pi         = 8'hC3;
      next_cycle;
      load_valid = 1'b0;
      shift_en   = 1'b1;
      next_cycle;
      next_cycle;
      next_cycle;
      settle;
      chk("midrst_pre_busy", l_busy, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_idle("midrst_during");
      #1;
      rst_n    = 1'b1;
      shift_en = 1'b0;
      next_cycle;
      settle;
      chk_idle("midrst_after");
      $display("[TB] async reset mid-word done, fails so far %0d", n_fail);
      next_cycle;

      // ---- recovery after reset ----
      run_word("5a", 8'h5A, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
